// File: rtl/rx_uart_pkg.sv
// Shared types and constants for the 8N1 UART receiver that drives the LED bank.
package rx_uart_pkg;

  localparam int CLKS_PER_BIT = 10;
  localparam int DATA_BITS    = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_t;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  // Terminal line controls never reach the LEDs.
  function automatic logic is_line_ctrl(input logic [7:0] b);
    return (b == ASCII_LF) || (b == ASCII_CR);
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receive engine: line synchronizer, frame FSM and LSB-first shift register.
module uart_rx_core
  import rx_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT_P = CLKS_PER_BIT,
  parameter int DATA_BITS_P    = DATA_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  output logic [DATA_BITS_P-1:0] rx_byte,
  output logic                   byte_valid,
  output logic                   frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT_P);
  localparam int IW = $clog2(DATA_BITS_P);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT_P - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT_P / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS_P - 1);

  logic [1:0]             sync_r;
  logic                   rx_s;
  state_t                 state_r, state_s;
  logic [CW-1:0]          cnt_r, cnt_s;
  logic [IW-1:0]          idx_r, idx_s;
  logic [DATA_BITS_P-1:0] shift_r, shift_s;
  logic                   valid_r, valid_s;
  logic                   err_r, err_s;

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rx};
    end
  end

  assign rx_s = sync_r[1];

  // FSM, counters, shift register and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      idx_r   <= '0;
      shift_r <= '0;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      shift_r <= shift_s;
      valid_r <= valid_s;
      err_r   <= err_s;
    end
  end

  // Next-state: bits are sampled mid-bit, aligned by the half-bit start check.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    shift_s = shift_r;
    valid_s = 1'b0;
    err_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!rx_s) begin
          cnt_s   = '0;
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == HALF_LAST) begin
          cnt_s = '0;
          if (!rx_s) begin
            idx_s   = '0;
            state_s = DATA;
          end else begin
            state_s = IDLE;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      DATA: begin
        if (cnt_r == BIT_LAST) begin
          cnt_s          = '0;
          shift_s[idx_r] = rx_s;
          if (idx_r == IDX_LAST) begin
            state_s = STOP;
          end else begin
            idx_s = idx_r + IW'(1);
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      STOP: begin
        if (cnt_r == BIT_LAST) begin
          cnt_s   = '0;
          state_s = CLEANUP;
          if (rx_s) begin
            valid_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      CLEANUP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign rx_byte    = shift_r;
  assign byte_valid = valid_r;
  assign frame_err  = err_r;

endmodule

// File: rtl/rx_uart_top.sv
// UART receiver top: serial line in, last printable byte held on the LED bank.
module rx_uart_top
  import rx_uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_serial,
  output logic [7:0] out_to_leds_top
);

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       frame_err;
  logic [7:0] leds_r;

  uart_rx_core #(
    .CLKS_PER_BIT_P(CLKS_PER_BIT),
    .DATA_BITS_P   (DATA_BITS)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .rx        (bit_serial),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  // LED register: load only good frames that are not LF/CR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      leds_r <= 8'h00;
    end else if (byte_valid && !frame_err && !is_line_ctrl(rx_byte)) begin
      leds_r <= rx_byte;
    end else begin
      leds_r <= leds_r;
    end
  end

  assign out_to_leds_top = leds_r;

endmodule

// File: tb/tb_rx_uart_top.sv
// Directed self-checking bench for rx_uart_top (10 clk per bit, 8N1, LSB first).
module tb_rx_uart_top;
  import rx_uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_serial;
  logic [7:0] out_to_leds_top;

  int total = 0;
  int bad   = 0;
  int cyc = 0, valid_cnt = 0, err_cnt = 0, valid_cyc = 0, chg_cyc = 0;
  logic [7:0] prev_out = 8'h00;

  always #10 clk = ~clk;

  rx_uart_top dut (
    .clk            (clk),
    .rst            (rst),
    .bit_serial     (bit_serial),
    .out_to_leds_top(out_to_leds_top)
  );

  // Pulse counters and LED-change timestamps for latency checks.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (dut.u_core.byte_valid) begin
      valid_cnt = valid_cnt + 1;
      valid_cyc = cyc;
    end
    if (dut.u_core.frame_err) err_cnt = err_cnt + 1;
    if (out_to_leds_top !== prev_out) chg_cyc = cyc;
    prev_out = out_to_leds_top;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    if (obs !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    bit_serial = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    bit_serial = b;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, e0, lat;
    logic found;
    rst        = 1'b1;
    bit_serial = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(5);
    check_val("rst_out", 32'(out_to_leds_top), 32'h00);
    check_val("rst_valid", 32'(valid_cnt), 32'd0);
    check_val("rst_state", 32'(dut.u_core.state_r), 32'(IDLE));

    // Single 'A'
    send_frame(8'h41, 1'b1);
    idle_cycles(3);
    lat = chg_cyc - valid_cyc;
    check_val("a_out", 32'(out_to_leds_top), 32'h41);
    check_val("a_valid", 32'(valid_cnt), 32'd1);
    check_val("a_latency", 32'((lat >= 0) && (lat <= 2)), 32'd1);

    send_frame(8'h33, 1'b1);
    idle_cycles(3);
    check_val("x33_out", 32'(out_to_leds_top), 32'h33);

    // 'A', LF, CR back-to-back
    v0 = valid_cnt;
    send_frame(8'h41, 1'b1);
    send_frame(8'h0A, 1'b1);
    send_frame(8'h0D, 1'b1);
    idle_cycles(5);
    check_val("b2b_valid", 32'(valid_cnt - v0), 32'd3);
    check_val("b2b_out", 32'(out_to_leds_top), 32'h41);
    check_val("b2b_last_byte", 32'(dut.u_core.rx_byte), 32'h0D);

    // Framing error
    v0 = valid_cnt;
    e0 = err_cnt;
    send_frame(8'h55, 1'b0);
    idle_cycles(20);
    check_val("ferr_err", 32'(err_cnt - e0), 32'd1);
    check_val("ferr_valid", 32'(valid_cnt - v0), 32'd0);
    check_val("ferr_out", 32'(out_to_leds_top), 32'h41);

    // Line held low: repeated framing errors, release while in START
    v0 = valid_cnt;
    e0 = err_cnt;
    bit_serial = 1'b0;
    repeat (250) @(negedge clk);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (dut.u_core.state_r == START) found = 1'b1;
    end
    bit_serial = 1'b1;
    idle_cycles(30);
    check_val("low_start_seen", 32'(found), 32'd1);
    check_val("low_errs", 32'((err_cnt - e0) >= 2), 32'd1);
    check_val("low_valid", 32'(valid_cnt - v0), 32'd0);
    check_val("low_out", 32'(out_to_leds_top), 32'h41);

    // 3-clk glitch
    v0 = valid_cnt;
    e0 = err_cnt;
    bit_serial = 1'b0;
    repeat (3) @(negedge clk);
    idle_cycles(20);
    check_val("glitch_state", 32'(dut.u_core.state_r), 32'(IDLE));
    check_val("glitch_valid", 32'(valid_cnt - v0), 32'd0);
    check_val("glitch_err", 32'(err_cnt - e0), 32'd0);
    check_val("glitch_out", 32'(out_to_leds_top), 32'h41);

    // Reset during data bit 4
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h5A >> i));
    bit_serial = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("midrst_out", 32'(out_to_leds_top), 32'h00);
    rst = 1'b0;
    @(negedge clk);
    check_val("midrst_state", 32'(dut.u_core.state_r), 32'(IDLE));
    idle_cycles(30);
    v0 = valid_cnt;
    send_frame(8'h5A, 1'b1);
    idle_cycles(5);
    check_val("post_rst_out", 32'(out_to_leds_top), 32'h5A);
    check_val("post_rst_valid", 32'(valid_cnt - v0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
